des_key_scheduler: RTL and testbench
====================================

// Module: des_key_scheduler
// PURPOSE
//  Sequential DES key schedule feeding the 48-bit i_key of each round mixer.
//  - Loads a 64-bit key and emits subkeys K1..K16, one per accepted handshake (encrypt order).
//  - Emits K16..K1 in decrypt mode.
//  - Holds C/D halves in registers, so no 16x48-bit subkey storage.
//  - Sits upstream of the round mixer/round iterator, which consumes o_subkey under valid/ready.
// PARAMETERS
//  KEY_WIDTH     64  input key width incl. parity; only 64 supported
//  SUBKEY_WIDTH  48  round subkey width; only 48 supported
//  ROUNDS        16  subkeys per schedule; only 16 supported
// PORTS
//  i_clk      in   1   clock; all logic on rising edge
//  i_rst      in   1   synchronous reset, active-high
//  i_start    in   1   start request; accepted only in IDLE
//  i_key      in   64  DES key, DES bit 1 = i_key[63]; parity bits (8,16..64) ignored
//  i_decrypt  in   1   sampled with i_start: 0 = K1..K16, 1 = K16..K1
//  i_ready    in   1   consumer accepts o_subkey this cycle
//  o_subkey   out  48  current subkey = PC2(C,D), DES bit 1 = o_subkey[47]
//  o_round    out  4   index of presented subkey 1..16 (key number, not transfer count); 0 when idle
//  o_valid    out  1   o_subkey/o_round valid
//  o_busy     out  1   schedule in progress (state RUN)
//  o_done     out  1   one-cycle pulse after final subkey transfer
// BEHAVIOUR
//  Reset: state IDLE; C=D=0; cnt=0; o_valid/o_busy/o_done=0; o_round=0.
//  - o_subkey is 0 whenever C=D=0, so it is 0 out of reset.
//  FSM states: IDLE, RUN.
//  - IDLE -> RUN on i_start.
//  - RUN -> IDLE on a transfer with cnt==16.
//  Start, cycle T, in IDLE with i_start=1:
//  - (C,D) <= PC1(i_key), rotated left by SHIFT[1] if encrypt, unrotated if decrypt.
//  - cnt <= 1; mode <= i_decrypt.
//  RUN:
//  - o_valid=1, o_busy=1; first subkey valid at T+1 (latency 1).
//  - o_round = cnt (encrypt) or 17-cnt (decrypt).
//  Transfer = o_valid & i_ready. On transfer with cnt<16:
//  - cnt++.
//  - Encrypt: rotate C and D left by SHIFT[cnt+1].
//  - Decrypt: rotate C and D right by SHIFT[18-(cnt+1)].
//  - SHIFT[r] = 1 for r in {1,2,9,16}, else 2; rotations are within each 28-bit half.
//  - Decrypt needs no pre-rotation: K16 = PC2(C0,D0) because total rotation is 28.
//  On transfer with cnt==16: state IDLE, o_valid=0, o_round=0, o_done=1 for exactly one cycle.
//  No transfer (i_ready=0): hold o_subkey, o_round, C, D, cnt unchanged; o_valid stays 1.
//  With i_ready tied high: subkeys at T+1..T+16, o_done at T+17, new i_start accepted at T+17.
//  i_start while in RUN: ignored; i_key/i_decrypt not sampled.
//  i_start in the same cycle as o_done: accepted, since state is already IDLE.
//  i_rst mid-schedule: abort immediately to reset values; no o_done.
//  All state registered; o_subkey is combinational PC2 of registered C/D only (no i_key path).
// STRUCTURE
//  des_pkg (shared with round logic):
//  - PC1 table (64->56), PC2 table (56->48), SHIFT[1:16].
//  - DES_ROUNDS=16.
//  - State encoding localparams IDLE/RUN.
//  Sub-module des_pc2_permute: combinational 56->48 PC2 wiring, reused by any future unrolled schedule.
//  Top: FSM, cnt, C/D registers with left/right rotate mux.
// TESTING
//  All vectors: i_key=64'h133457799BBCDFF1.
//  1. Encrypt, i_ready=1: K1=48'h1B02EFFC7072 at T+1, K2=48'h79AED9DBC9E5 at T+2.
//     K16=48'hCB3D8B0E17F5 at T+16, o_done at T+17.
//  2. Decrypt, same key: first output o_round=16, o_subkey=48'hCB3D8B0E17F5.
//     Last output o_round=1, o_subkey=48'h1B02EFFC7072.
//     All 16 match scenario 1 reversed.
//  3. Backpressure: random i_ready (~50%): transferred sequence identical to scenario 1.
//     Subkey stable while i_ready=0; exactly 16 transfers; one o_done.
//  4. Flip all parity bits of i_key: identical subkeys to scenario 1.
//     Pulse i_start mid-run with another key: no effect on current schedule.
//  5. Assert i_rst at round 7: next cycle o_valid=0, o_subkey=0, o_round=0, no o_done.
//     Restart yields a full correct schedule.
//  6. Back-to-back: i_start held high, encrypt then decrypt.
//     Second start accepted in the o_done cycle; both sequences correct with zero idle gap.

Source files
------------

// File: rtl/des_pkg.sv
// des_pkg: shared DES tables, round count, scheduler state encoding and bit helpers
package des_pkg;

    localparam int DES_ROUNDS = 16;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int SHIFT [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
        return r;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_pc2_permute.sv
// des_pc2_permute: combinational PC2 wiring from {C,D} (56 bits) to a 48-bit subkey
module des_pc2_permute
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subkey
);

    genvar i;
    for (i = 0; i < 48; i++) begin : g_bit
        assign subkey[47-i] = cd[56-PC2[i]];
    end

    logic unused_cd;
    assign unused_cd = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_key_scheduler.sv
// des_key_scheduler: sequential DES subkey generator, K1..K16 or K16..K1 under valid/ready
module des_key_scheduler
    import des_pkg::*;
#(
    parameter int KEY_WIDTH    = 64,
    parameter int SUBKEY_WIDTH = 48,
    parameter int ROUNDS       = DES_ROUNDS
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [KEY_WIDTH-1:0]    i_key,
    input  logic                    i_decrypt,
    input  logic                    i_ready,
    output logic [SUBKEY_WIDTH-1:0] o_subkey,
    output logic [3:0]              o_round,
    output logic                    o_valid,
    output logic                    o_busy,
    output logic                    o_done
);

    state_t      state;
    logic [27:0] c, d;
    logic [4:0]  cnt, nr;
    logic        mode, two;
    logic [55:0] pk;

    assign pk      = pc1(i_key);
    assign o_valid = state == RUN;
    assign o_busy  = state == RUN;

    always_comb begin
        nr      = mode ? 5'd17 - cnt : cnt + 5'd1;
        two     = (nr inside {[5'd1:5'd16]}) ? SHIFT[int'(nr)] == 2 : 1'b0;
        o_round = (state == RUN) ? (mode ? 4'(5'd17 - cnt) : cnt[3:0]) : 4'd0;
    end

    des_pc2_permute u_pc2 (
        .cd     ({c, d}),
        .subkey (o_subkey)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            c      <= '0;
            d      <= '0;
            cnt    <= '0;
            mode   <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (state == IDLE) begin
                if (i_start) begin
                    state <= RUN;
                    cnt   <= 5'd1;
                    mode  <= i_decrypt;
                    c     <= i_decrypt ? pk[55:28] : rotl(pk[55:28], SHIFT[1] == 2);
                    d     <= i_decrypt ? pk[27:0] : rotl(pk[27:0], SHIFT[1] == 2);
                end
            end else if (i_ready) begin
                if (cnt == 5'(ROUNDS)) begin
                    state  <= IDLE;
                    cnt    <= '0;
                    o_done <= 1'b1;
                end else begin
                    cnt <= cnt + 5'd1;
                    c   <= mode ? rotr(c, two) : rotl(c, two);
                    d   <= mode ? rotr(d, two) : rotl(d, two);
                end
            end
        end
    end

endmodule

// File: tb/tb_des_key_scheduler.sv
// tb_des_key_scheduler: randomized self-checking bench against an array-based DES key schedule model
module tb_des_key_scheduler;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_decrypt = 1'b0;
    logic        i_ready = 1'b0;
    logic [63:0] i_key = '0;
    logic [47:0] o_subkey;
    logic [3:0]  o_round;
    logic        o_valid, o_busy, o_done;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
    localparam logic [47:0] K1   = 48'h1B02EFFC7072;
    localparam logic [47:0] K2   = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;
    localparam logic [63:0] PAR  = 64'h0101010101010101;

    localparam int T_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int T_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int T_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic [47:0] mk [16];
    logic [47:0] tk [$];
    logic [3:0]  tr [$];
    int          tc [$];
    int          dc [$];
    int          hold_bad;

    des_key_scheduler dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_key     (i_key),
        .i_decrypt (i_decrypt),
        .i_ready   (i_ready),
        .o_subkey  (o_subkey),
        .o_round   (o_round),
        .o_valid   (o_valid),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    // Encrypt-order subkeys: each half rotated by the cumulative shift, looked up modulo 28.
    task automatic build_model(input logic [63:0] key);
        int rot, idx, p;
        rot = 0;
        for (int r = 0; r < 16; r++) begin
            rot += T_SHIFT[r];
            for (int j = 0; j < 48; j++) begin
                idx = T_PC2[j];
                p = (idx <= 28) ? (idx - 1 + rot) % 28 : 28 + (idx - 29 + rot) % 28;
                mk[r][47-j] = key[64 - T_PC1[p]];
            end
        end
    endtask

    task automatic do_start(input logic [63:0] key, input logic dec);
        i_key = key;
        i_decrypt = dec;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic collect(input int pct, input int want_done, input int ms);
        logic [47:0] pk;
        logic [3:0]  pr;
        bit          stall;
        stall = 0;
        pk = '0;
        pr = '0;
        tk.delete(); tr.delete(); tc.delete(); dc.delete();
        hold_bad = 0;
        for (int cyc = 0; cyc < 400 && dc.size() < want_done; cyc++) begin
            if (stall && (o_valid !== 1'b1 || o_subkey !== pk || o_round !== pr)) hold_bad++;
            if (o_done === 1'b1) begin
                dc.push_back(cyc);
                if (dc.size() == want_done) i_start = 1'b0;
            end
            if (ms >= 0) begin
                i_start = (cyc == ms);
                if (cyc == ms) begin
                    i_key = {$urandom, $urandom};
                    i_decrypt = ~i_decrypt;
                end
            end
            i_ready = ($urandom_range(99) < pct);
            if (o_valid && i_ready) begin
                tk.push_back(o_subkey);
                tr.push_back(o_round);
                tc.push_back(cyc);
            end
            stall = o_valid && !i_ready;
            pk = o_subkey;
            pr = o_round;
            @(posedge i_clk); #1;
        end
        i_ready = 1'b0;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        i_start = 1'b1;
        i_key = KEY;
        repeat (2) @(posedge i_clk);
        #1;
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", o_valid); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", o_busy); end
        vectors++; if (o_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", o_done); end
        vectors++; if (o_round !== 4'd0) begin miscompares++; $display("FAIL reset_round got %0d want 0", o_round); end
        vectors++; if (o_subkey !== 48'd0) begin miscompares++; $display("FAIL reset_subkey got %h want 0", o_subkey); end
        i_start = 1'b0;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid got %b want 0", o_valid); end
    endtask

    task automatic test_encrypt;
        build_model(KEY);
        do_start(KEY, 1'b0);
        collect(100, 1, -1);
        vectors++; if (tk.size() != 16) begin miscompares++; $display("FAIL enc_count got %0d want 16", tk.size()); end
        else begin
            vectors++; if (tk[0] !== K1) begin miscompares++; $display("FAIL enc_k1 got %h want %h", tk[0], K1); end
            vectors++; if (tk[1] !== K2) begin miscompares++; $display("FAIL enc_k2 got %h want %h", tk[1], K2); end
            vectors++; if (tk[15] !== K16) begin miscompares++; $display("FAIL enc_k16 got %h want %h", tk[15], K16); end
            for (int i = 0; i < 16; i++) begin
                vectors++; if (tk[i] !== mk[i]) begin miscompares++; $display("FAIL enc_key[%0d] got %h want %h", i, tk[i], mk[i]); end
                vectors++; if (tr[i] !== 4'(i + 1)) begin miscompares++; $display("FAIL enc_round[%0d] got %0d want %0d", i, tr[i], 4'(i + 1)); end
                vectors++; if (tc[i] != i) begin miscompares++; $display("FAIL enc_cycle[%0d] got %0d want %0d", i, tc[i], i); end
            end
        end
        vectors++; if (dc.size() != 1 || dc[0] != 16) begin miscompares++; $display("FAIL enc_done count %0d cycle %0d want 1 at 16", dc.size(), dc.size() ? dc[0] : -1); end
        vectors++; if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_round !== 4'd0) begin miscompares++; $display("FAIL enc_after got v%b b%b r%0d want 0 0 0", o_valid, o_busy, o_round); end
    endtask

    task automatic test_decrypt;
        build_model(KEY);
        do_start(KEY, 1'b1);
        collect(100, 1, -1);
        vectors++; if (tk.size() != 16) begin miscompares++; $display("FAIL dec_count got %0d want 16", tk.size()); end
        else begin
            vectors++; if (tk[0] !== K16 || tr[0] !== 4'(16)) begin miscompares++; $display("FAIL dec_first got %h r%0d want %h r%0d", tk[0], tr[0], K16, 4'(16)); end
            vectors++; if (tk[15] !== K1 || tr[15] !== 4'd1) begin miscompares++; $display("FAIL dec_last got %h r%0d want %h r1", tk[15], tr[15], K1); end
            for (int i = 0; i < 16; i++) begin
                vectors++; if (tk[i] !== mk[15-i]) begin miscompares++; $display("FAIL dec_key[%0d] got %h want %h", i, tk[i], mk[15-i]); end
                vectors++; if (tr[i] !== 4'(16 - i)) begin miscompares++; $display("FAIL dec_round[%0d] got %0d want %0d", i, tr[i], 4'(16 - i)); end
            end
        end
        vectors++; if (dc.size() != 1 || dc[0] != 16) begin miscompares++; $display("FAIL dec_done count %0d want 1 at 16", dc.size()); end
    endtask

    task automatic test_backpressure;
        int extra;
        build_model(KEY);
        do_start(KEY, 1'b0);
        collect(50, 1, -1);
        vectors++; if (tk.size() != 16) begin miscompares++; $display("FAIL bp_count got %0d want 16", tk.size()); end
        else for (int i = 0; i < 16; i++) begin
            vectors++; if (tk[i] !== mk[i]) begin miscompares++; $display("FAIL bp_key[%0d] got %h want %h", i, tk[i], mk[i]); end
        end
        vectors++; if (hold_bad != 0) begin miscompares++; $display("FAIL bp_hold got %0d unstable stalls want 0", hold_bad); end
        extra = 0;
        repeat (4) begin
            if (o_done === 1'b1) extra++;
            @(posedge i_clk); #1;
        end
        vectors++; if (dc.size() != 1 || extra != 0) begin miscompares++; $display("FAIL bp_done got %0d pulses want 1", dc.size() + extra); end
    endtask

    task automatic test_parity_and_ignored_start;
        build_model(KEY);
        do_start(KEY ^ PAR, 1'b0);
        collect(60, 1, 5);
        vectors++; if (tk.size() != 16) begin miscompares++; $display("FAIL par_count got %0d want 16", tk.size()); end
        else for (int i = 0; i < 16; i++) begin
            vectors++; if (tk[i] !== mk[i]) begin miscompares++; $display("FAIL par_key[%0d] got %h want %h", i, tk[i], mk[i]); end
            vectors++; if (tr[i] !== 4'(i + 1)) begin miscompares++; $display("FAIL par_round[%0d] got %0d want %0d", i, tr[i], 4'(i + 1)); end
        end
        vectors++; if (dc.size() != 1) begin miscompares++; $display("FAIL par_done got %0d want 1", dc.size()); end
        vectors++; if (hold_bad != 0) begin miscompares++; $display("FAIL par_hold got %0d want 0", hold_bad); end
    endtask

    task automatic test_reset_mid;
        int n, extra;
        logic [63:0] rk;
        logic dm;
        do_start(KEY, 1'b0);
        i_ready = 1'b1;
        n = 0;
        while (o_round !== 4'd7 && n < 40) begin
            @(posedge i_clk); #1;
            n++;
        end
        vectors++; if (o_round !== 4'd7) begin miscompares++; $display("FAIL rst_reach got %0d want 7", o_round); end
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        vectors++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid got v%b b%b want 0 0", o_valid, o_busy); end
        vectors++; if (o_subkey !== 48'd0) begin miscompares++; $display("FAIL rst_mid_subkey got %h want 0", o_subkey); end
        vectors++; if (o_round !== 4'd0) begin miscompares++; $display("FAIL rst_mid_round got %0d want 0", o_round); end
        i_rst = 1'b0;
        i_ready = 1'b0;
        extra = 0;
        repeat (4) begin
            if (o_done === 1'b1) extra++;
            @(posedge i_clk); #1;
        end
        vectors++; if (extra != 0) begin miscompares++; $display("FAIL rst_mid_done got %0d pulses want 0", extra); end
        rk = {$urandom, $urandom};
        dm = 1'($urandom_range(1));
        build_model(rk);
        do_start(rk, dm);
        collect(70, 1, -1);
        vectors++; if (tk.size() != 16) begin miscompares++; $display("FAIL restart_count got %0d want 16", tk.size()); end
        else for (int i = 0; i < 16; i++) begin
            vectors++; if (tk[i] !== (dm ? mk[15-i] : mk[i])) begin miscompares++; $display("FAIL restart_key[%0d] got %h want %h", i, tk[i], dm ? mk[15-i] : mk[i]); end
        end
    endtask

    task automatic test_back_to_back;
        build_model(KEY);
        i_key = KEY;
        i_decrypt = 1'b0;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_decrypt = 1'b1;
        collect(100, 2, -1);
        i_start = 1'b0;
        vectors++; if (tk.size() != 32) begin miscompares++; $display("FAIL b2b_count got %0d want 32", tk.size()); end
        else for (int i = 0; i < 16; i++) begin
            vectors++; if (tk[i] !== mk[i] || tc[i] != i) begin miscompares++; $display("FAIL b2b_enc[%0d] got %h@%0d want %h@%0d", i, tk[i], tc[i], mk[i], i); end
            vectors++; if (tk[16+i] !== mk[15-i] || tc[16+i] != 17 + i || tr[16+i] !== 4'(16 - i)) begin
                miscompares++; $display("FAIL b2b_dec[%0d] got %h@%0d r%0d want %h@%0d r%0d", i, tk[16+i], tc[16+i], tr[16+i], mk[15-i], 17 + i, 4'(16 - i));
            end
        end
        vectors++; if (dc.size() != 2 || dc[0] != 16 || dc[1] != 33) begin miscompares++; $display("FAIL b2b_done got %0d pulses want 2 at 16,33", dc.size()); end
    endtask

    task automatic test_random_keys;
        logic [63:0] rk;
        logic dm;
        for (int t = 0; t < 4; t++) begin
            rk = {$urandom, $urandom};
            dm = 1'($urandom_range(1));
            build_model(rk);
            do_start(rk, dm);
            collect(int'($urandom_range(100, 30)), 1, -1);
            vectors++; if (tk.size() != 16) begin miscompares++; $display("FAIL rand_count[%0d] got %0d want 16", t, tk.size()); end
            else for (int i = 0; i < 16; i++) begin
                vectors++; if (tk[i] !== (dm ? mk[15-i] : mk[i])) begin miscompares++; $display("FAIL rand_key[%0d][%0d] got %h want %h", t, i, tk[i], dm ? mk[15-i] : mk[i]); end
            end
            vectors++; if (hold_bad != 0 || dc.size() != 1) begin miscompares++; $display("FAIL rand_proto[%0d] got hold %0d done %0d want 0 1", t, hold_bad, dc.size()); end
        end
    endtask

    initial begin
        test_reset;
        test_encrypt;
        test_decrypt;
        test_backpressure;
        test_parity_and_ignored_start;
        test_reset_mid;
        test_back_to_back;
        test_random_keys;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
